// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared definitions for the fetch-stage branch predictor:
//                branch class encoding, RV32I opcode[6:2] constants and
//                immediate extraction helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    typedef enum logic [1:0] {
        BR_CLASS_OTHER = 2'd0,
        BR_CLASS_COND  = 2'd1,
        BR_CLASS_JALR  = 2'd2,
        BR_CLASS_JAL   = 2'd3
    } br_class_e;

    // instr[6:2] values; instr[1:0] is always 2'b11 for 32-bit encodings
    localparam logic [4:0] OPC_BRANCH = 5'h18;
    localparam logic [4:0] OPC_JALR   = 5'h19;
    localparam logic [4:0] OPC_JAL    = 5'h1B;

    // B-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // x1 (ra) and x5 (t0) are the link registers for call/return hinting
    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_counter_table.sv
`default_nettype none
// ============================================================================
//  Module      : branch_counter_table
//  Description : Array of saturating direction counters. Combinational read
//                of the registered value (a same-cycle write is not bypassed),
//                saturating increment/decrement at the clock edge.
//  Ports       : clk, reset_n     - clock, async active-low reset
//                rd_idx / rd_taken - read index, MSB of the addressed counter
//                wr_en/wr_idx/wr_taken - training strobe, index, outcome
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_counter_table #(
    parameter  int DEPTH    = 64,
    parameter  int CTR_BITS = 2,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // 2^(CTR_BITS-1)-1: weakly not-taken
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

    logic [CTR_BITS-1:0] ctr_q [DEPTH];
    logic [CTR_BITS-1:0] ctr_d [DEPTH];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) begin
            if (wr_taken) begin
                if (ctr_q[wr_idx] != CTR_MAX)
                    ctr_d[wr_idx] = ctr_q[wr_idx] + CTR_BITS'(1);
            end else begin
                if (ctr_q[wr_idx] != '0)
                    ctr_d[wr_idx] = ctr_q[wr_idx] - CTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign rd_taken = ctr_q[rd_idx][CTR_BITS-1];

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Fetch-stage next-PC predictor. Classifies the fetched
//                instruction, predicts direction from a counter table and
//                registers {valid, pc, taken, target, class} one cycle later.
//                Trained by execute-stage resolutions.
//  Ports       : clk, reset_n                      - clock, async active-low reset
//                fetch_valid/fetch_pc/fetch_instr  - fetched instruction
//                flush                             - kill the prediction in flight
//                pred_valid/pc/taken/target/class  - registered prediction
//                resolve_valid/pc/taken            - training interface
//  Options     : BRANCH_PREDICTOR_RAS_EN - adds a RAS_DEPTH-entry return
//                address stack for call/return prediction.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_BITS  = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [31:0]     fetch_instr,
    input  logic            flush,
    output logic            pred_valid,
    output logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [1:0]      pred_class,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic            resolve_taken
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic            fetch_fire;
    logic            ctr_taken;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jal_target;
    br_class_e       cls;
    logic            taken;
    logic [XLEN-1:0] target;

    logic            pred_valid_q, pred_valid_d;
    logic [XLEN-1:0] pred_pc_q, pred_pc_d;
    logic            pred_taken_q, pred_taken_d;
    logic [XLEN-1:0] pred_target_q, pred_target_d;
    br_class_e       pred_class_q, pred_class_d;

    assign fetch_fire = fetch_valid & ~flush;

    branch_counter_table #(
        .DEPTH    (BHT_DEPTH),
        .CTR_BITS (CTR_BITS)
    ) u_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (fetch_pc[IDX_W+1:2]),
        .rd_taken (ctr_taken),
        .wr_en    (resolve_valid),
        .wr_idx   (resolve_pc[IDX_W+1:2]),
        .wr_taken (resolve_taken)
    );

    // Immediates are sign-extended/truncated to XLEN; sums wrap mod 2^XLEN
    assign pc_plus4   = fetch_pc + XLEN'(4);
    assign br_target  = fetch_pc + XLEN'($signed(imm_b(fetch_instr)));
    assign jal_target = fetch_pc + XLEN'($signed(imm_j(fetch_instr)));

`ifdef BRANCH_PREDICTOR_RAS_EN
    localparam int RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]      ras_q [RAS_DEPTH];
    logic [XLEN-1:0]      ras_d [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_sp_q, ras_sp_d;   // next slot to write
    logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d; // valid entries, saturates at depth
    logic [RAS_PTR_W-1:0] ras_top;
    logic                 ras_push, ras_pop;

    assign ras_top = (ras_sp_q == '0) ? RAS_PTR_W'(RAS_DEPTH - 1)
                                      : ras_sp_q - RAS_PTR_W'(1);
`endif

    always_comb begin
        cls    = BR_CLASS_OTHER;
        taken  = 1'b0;
        target = pc_plus4;
`ifdef BRANCH_PREDICTOR_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        case (fetch_instr[6:2])
            OPC_BRANCH: begin
                cls    = BR_CLASS_COND;
                taken  = ctr_taken;
                target = ctr_taken ? br_target : pc_plus4;
            end
            OPC_JAL: begin
                cls    = BR_CLASS_JAL;
                taken  = 1'b1;
                target = jal_target;
`ifdef BRANCH_PREDICTOR_RAS_EN
                ras_push = is_link_reg(fetch_instr[11:7]);
`endif
            end
            OPC_JALR: begin
                cls = BR_CLASS_JALR;
`ifdef BRANCH_PREDICTOR_RAS_EN
                // Return: use the stack if it holds anything; a link-to-link
                // JALR pops and then pushes its own return address.
                if (is_link_reg(fetch_instr[19:15]) && (ras_cnt_q != '0)) begin
                    ras_pop = 1'b1;
                    taken   = 1'b1;
                    target  = ras_q[ras_top];
                end
                ras_push = is_link_reg(fetch_instr[11:7]);
`endif
            end
            default: ;
        endcase
    end

`ifdef BRANCH_PREDICTOR_RAS_EN
    always_comb begin
        ras_d     = ras_q;
        ras_sp_d  = ras_sp_q;
        ras_cnt_d = ras_cnt_q;
        if (fetch_fire) begin
            if (ras_pop) begin
                ras_sp_d  = ras_top;
                ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
            end
            if (ras_push) begin
                ras_d[ras_sp_d] = pc_plus4;
                ras_sp_d = (ras_sp_d == RAS_PTR_W'(RAS_DEPTH - 1)) ? '0
                                                                   : ras_sp_d + RAS_PTR_W'(1);
                // When full the oldest entry was just overwritten
                if (ras_cnt_d != RAS_CNT_W'(RAS_DEPTH))
                    ras_cnt_d = ras_cnt_d + RAS_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            ras_sp_q  <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_q     <= ras_d;
            ras_sp_q  <= ras_sp_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end
`else
    // Low/high bits with no role in the default build
    logic unused_bits;
    assign unused_bits = ^{fetch_instr[1:0], (RAS_DEPTH != 0)};
`endif

    logic unused_resolve;
    assign unused_resolve = ^{resolve_pc[XLEN-1:IDX_W+2], resolve_pc[1:0]};

    // Payload only advances on a live prediction; otherwise it holds
    always_comb begin
        pred_valid_d  = fetch_fire;
        pred_pc_d     = pred_pc_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        pred_class_d  = pred_class_q;
        if (fetch_fire) begin
            pred_pc_d     = fetch_pc;
            pred_taken_d  = taken;
            pred_target_d = target;
            pred_class_d  = cls;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid_q  <= 1'b0;
            pred_pc_q     <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_class_q  <= BR_CLASS_OTHER;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_pc_q     <= pred_pc_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            pred_class_q  <= pred_class_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_pc     = pred_pc_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign pred_class  = pred_class_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed table-driven bench for branch_predictor with a few
//                hand-written multi-cycle sequences (reset, async reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        flush;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pred_class;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN(32), .BHT_DEPTH(64), .CTR_BITS(2), .RAS_DEPTH(4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_instr   (fetch_instr),
        .flush         (flush),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_class    (pred_class),
        .resolve_valid (resolve_valid),
        .resolve_pc    (resolve_pc),
        .resolve_taken (resolve_taken)
    );

    // Hand-assembled encodings
    localparam logic [31:0] I_BEQ_P16  = 32'h00000863; // beq x0,x0,+16
    localparam logic [31:0] I_BEQ_M4   = 32'hFE000EE3; // beq x0,x0,-4
    localparam logic [31:0] I_JAL_X0   = 32'h0100006F; // jal x0,+16
    localparam logic [31:0] I_JAL_X1   = 32'h010000EF; // jal x1,+16
    localparam logic [31:0] I_JALR_RET = 32'h00008067; // jalr x0,0(x1)
    localparam logic [31:0] I_ADDI     = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] I_ILLEGAL  = 32'hFFFFFFFF;

    typedef struct packed {
        logic        fv;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rv;
        logic [31:0] rpc;
        logic        rt;
        logic        ev;
        logic        et;
        logic [1:0]  ec;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add_vec(input logic fv, input logic fl, input logic [31:0] pc,
                           input logic [31:0] instr, input logic rv,
                           input logic [31:0] rpc, input logic rt, input logic ev,
                           input logic et, input logic [1:0] ec, input logic [31:0] etgt);
        vec_t v;
        v = '{fv:fv, fl:fl, pc:pc, instr:instr, rv:rv, rpc:rpc, rt:rt,
              ev:ev, et:et, ec:ec, etgt:etgt};
        vecs.push_back(v);
    endtask

    task automatic add_fetch(input logic [31:0] pc, input logic [31:0] instr,
                             input logic et, input logic [1:0] ec, input logic [31:0] etgt);
        add_vec(1'b1, 1'b0, pc, instr, 1'b0, 32'h0, 1'b0, 1'b1, et, ec, etgt);
    endtask

    task automatic add_resolve(input logic [31:0] rpc, input logic rt, input int n);
        for (int k = 0; k < n; k++)
            add_vec(1'b0, 1'b0, 32'h0, I_ADDI, 1'b1, rpc, rt, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic check(input string name, input logic ev, input logic et,
                         input logic [1:0] ec, input logic [31:0] etgt,
                         input logic [31:0] epc);
        logic bad;
        n_vec++;
        bad = (pred_valid !== ev);
        if (ev)
            bad = bad || (pred_taken !== et) || (pred_class !== ec) ||
                  (pred_target !== etgt) || (pred_pc !== epc);
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got v=%0b t=%0b c=%0d tgt=%h pc=%h, want v=%0b t=%0b c=%0d tgt=%h pc=%h",
                     name, pred_valid, pred_taken, pred_class, pred_target, pred_pc,
                     ev, et, ec, etgt, epc);
        end
    endtask

    task automatic idle_inputs();
        fetch_valid   = 1'b0;
        fetch_pc      = 32'h0;
        fetch_instr   = I_ADDI;
        flush         = 1'b0;
        resolve_valid = 1'b0;
        resolve_pc    = 32'h0;
        resolve_taken = 1'b0;
    endtask

    initial begin
        // ---------------- vector table ----------------
        add_fetch(32'h100, I_BEQ_P16, 1'b0, 2'd1, 32'h104);      // ctr 1: NT
        add_resolve(32'h100, 1'b1, 3);                           // ctr 2,3,3
        add_fetch(32'h100, I_BEQ_P16, 1'b1, 2'd1, 32'h110);
        add_resolve(32'h100, 1'b1, 1);                           // stays 3
        add_fetch(32'h100, I_BEQ_P16, 1'b1, 2'd1, 32'h110);
        add_resolve(32'h100, 1'b1, 7);                           // stays 3
        add_fetch(32'h100, I_BEQ_P16, 1'b1, 2'd1, 32'h110);
        add_resolve(32'h100, 1'b0, 1);                           // 2
        add_fetch(32'h100, I_BEQ_M4, 1'b1, 2'd1, 32'h0FC);       // backward target
        add_resolve(32'h100, 1'b0, 1);                           // 1
        add_fetch(32'h100, I_BEQ_P16, 1'b0, 2'd1, 32'h104);
        add_resolve(32'h100, 1'b0, 3);                           // 0,0,0
        add_resolve(32'h100, 1'b1, 1);                           // 1
        add_fetch(32'h100, I_BEQ_P16, 1'b0, 2'd1, 32'h104);
        add_resolve(32'h100, 1'b1, 1);                           // 2
        add_fetch(32'h100, I_BEQ_P16, 1'b1, 2'd1, 32'h110);
        // flush beats fetch_valid; table unaffected
        add_vec(1'b1, 1'b1, 32'h100, I_BEQ_P16, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        add_fetch(32'h100, I_BEQ_P16, 1'b1, 2'd1, 32'h110);
        // JAL wrap at top of address space
        add_fetch(32'hFFFF_FFF8, I_JAL_X0, 1'b1, 2'd3, 32'h0000_0008);
        // same-cycle read/write of a weakly-not-taken entry
        add_vec(1'b1, 1'b0, 32'h040, I_BEQ_P16, 1'b1, 32'h040, 1'b1, 1'b1, 1'b0, 2'd1, 32'h044);
        add_fetch(32'h040, I_BEQ_P16, 1'b1, 2'd1, 32'h050);
        add_fetch(32'h1040, I_BEQ_P16, 1'b1, 2'd1, 32'h1050);   // aliases 0x40
        add_fetch(32'h200, I_JALR_RET, 1'b0, 2'd2, 32'h204);     // empty/no RAS
        add_fetch(32'h300, I_ADDI, 1'b0, 2'd0, 32'h304);
        add_fetch(32'h400, I_ILLEGAL, 1'b0, 2'd0, 32'h404);
`ifdef BRANCH_PREDICTOR_RAS_EN
        add_fetch(32'h200, I_JAL_X1, 1'b1, 2'd3, 32'h210);
        add_fetch(32'h210, I_JALR_RET, 1'b1, 2'd2, 32'h204);
        for (int k = 0; k < 5; k++)
            add_fetch(32'h200 + 32'(k) * 32'h100, I_JAL_X1, 1'b1, 2'd3,
                      32'h210 + 32'(k) * 32'h100);
        for (int k = 0; k < 4; k++)
            add_fetch(32'h700 + 32'(k) * 32'h100, I_JALR_RET, 1'b1, 2'd2,
                      32'h604 - 32'(k) * 32'h100);
        add_fetch(32'hB00, I_JALR_RET, 1'b0, 2'd2, 32'hB04);
`endif

        // ---------------- reset ----------------
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_vec++;
        if ({pred_valid, pred_taken, pred_class, pred_pc, pred_target} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%0b t=%0b c=%0d pc=%h tgt=%h, want all zero",
                     pred_valid, pred_taken, pred_class, pred_pc, pred_target);
        end

        // ---------------- table-driven run ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            fetch_valid   = vecs[i].fv;
            flush         = vecs[i].fl;
            fetch_pc      = vecs[i].pc;
            fetch_instr   = vecs[i].instr;
            resolve_valid = vecs[i].rv;
            resolve_pc    = vecs[i].rpc;
            resolve_taken = vecs[i].rt;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].et, vecs[i].ec,
                  vecs[i].etgt, vecs[i].pc);
        end

        // ---------------- asynchronous reset mid-operation ----------------
        @(negedge clk);
        idle_inputs();
        fetch_valid = 1'b1;
        fetch_pc    = 32'h040;
        fetch_instr = I_BEQ_P16;
        @(posedge clk);
        #1;
        check("pre_async_reset", 1'b1, 1'b1, 2'd1, 32'h050, 32'h040);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // table back to weakly not-taken
        check("post_reset_counter", 1'b1, 1'b0, 2'd1, 32'h044, 32'h040);

        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("idle_after", 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage next-PC predictor for the RV32I core; sits between instruction fetch and the PC mux.
- Decodes the branch class of each fetched instruction (conditional branch, JAL, JALR, other), predicts direction from a parametrised table of saturating counters, and computes the predicted target.
- Trains the table from execute-stage branch resolutions.

Parameters:
- XLEN, 32, address/PC width.
- BHT_DEPTH, 64, number of counter entries; power of two, ≥2.
- CTR_BITS, 2, width of each saturating counter; ≥1.
- RAS_DEPTH, 4, return-address-stack entries; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fetch_valid  in  1  fetch_pc/fetch_instr valid this cycle.
- fetch_pc  in  XLEN  PC of the fetched instruction.
- fetch_instr  in  32  fetched instruction word.
- flush  in  1  kill the prediction in flight.
- pred_valid  out  1  registered prediction valid.
- pred_pc  out  XLEN  PC the prediction belongs to.
- pred_taken  out  1  predicted redirect.
- pred_target  out  XLEN  predicted next PC.
- pred_class  out  2  0 other, 1 cond, 2 JALR, 3 JAL.
- resolve_valid  in  1  execute-stage resolution strobe.
- resolve_pc  in  XLEN  PC of the resolved conditional branch.
- resolve_taken  in  1  actual outcome.

Behaviour:
- Reset (asynchronous on reset_n low):
  - pred_valid=0, pred_taken=0, pred_pc=0, pred_target=0, pred_class=0.
  - Every counter = 2^(CTR_BITS-1)-1, i.e. weakly not-taken.
  - Reset asserted mid-operation discards all state immediately.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on pred_* after edge N; no backpressure.
- pred_valid(N+1) = fetch_valid(N) & ~flush(N).
  - flush has priority over fetch_valid.
  - flush never touches the counter table.
- Classification on fetch_instr[6:2]:
  - 0x18 → cond.
  - 0x19 → JALR.
  - 0x1B → JAL.
  - anything else → other; this includes illegal encodings.
- Table index = fetch_pc[log2(BHT_DEPTH)+1:2]; upper PC bits are ignored, so aliasing is permitted.
- Prediction per class:
  - cond: taken = counter MSB. Target = pc + sign-extended B-immediate when taken, pc+4 otherwise.
  - JAL: taken=1; target = pc + sign-extended J-immediate.
  - JALR: taken=0; target = pc+4, because the register value is unknown at fetch.
  - other: taken=0; target = pc+4.
- Arithmetic: all additions are modulo 2^XLEN, so wrap-around at the top of the address space is silent.
- Training:
  - When resolve_valid=1, the counter at the index derived from resolve_pc increments if resolve_taken=1, otherwise decrements.
  - Saturation: counter holds at 2^CTR_BITS-1 on increment and at 0 on decrement.
- Same-cycle read and write to one index: the prediction uses the pre-update value (no bypass). The update lands at the edge.
- pred_* outputs hold their values when pred_valid=0; they are don't-care to consumers.

Optional Feature:
- Macro: BRANCH_PREDICTOR_RAS_EN.
- Defined: adds a RAS_DEPTH-entry return address stack.
  - Push pc+4 on a predicted JAL or JALR with rd ∈ {x1,x5}.
  - Pop on a JALR with rs1 ∈ {x1,x5} and rd ∉ {x1,x5}: pred_taken=1, pred_target=popped value.
  - Push when full overwrites the oldest entry (circular wrap).
  - Pop when empty: taken=0, target=pc+4.
  - Push and pop in the same instruction (link-to-link JALR): pop, then push.
  - Stack updates only when the prediction is produced (fetch_valid & ~flush). Reset empties the stack.
- Undefined: no stack logic; every JALR predicts not-taken.

Decomposition:
- Shared package branch_pkg:
  - class encodings (BR_CLASS_OTHER/COND/JALR/JAL);
  - opcode constants 5'h18, 5'h19, 5'h1B;
  - immediate-extraction functions imm_b and imm_j.
- One sub-module, branch_counter_table: counter array with saturating update, async-reset initialisation, and read-before-write semantics.

Test Plan:
- Reset, then fetch BEQ at pc=0x100 with imm=+16 → pred_valid=1, class=1, taken=0, target=0x104.
- Three resolves of pc=0x100 taken, then refetch → taken=1, target=0x110. Eight further taken resolves keep counter at 3 and taken=1.
- JAL at pc=0xFFFFFFF8, imm=+0x10 → taken=1, target=0x00000008 (wrap).
- fetch_valid=1 with flush=1 → next-cycle pred_valid=0; a following BEQ fetch is still predicted from an unchanged table.
- Resolve and fetch of the same index in one cycle on a weakly-not-taken entry → that prediction not-taken; next fetch taken.
- With BRANCH_PREDICTOR_RAS_EN: JAL x1 at 0x200, then JALR x0,0(x1) → taken, target=0x204. Five calls with RAS_DEPTH=4 followed by five returns → first four returns correct, fifth predicts not-taken.
